// File: rtl/system_bus_pkg.sv
// Shared definitions for the two-master system bus.
//   WIDTH_DEFAULT : default address/data width in bits
//   master_e      : master index (M0 = core 0, M1 = core 1)
//   GNT_*         : one-hot grant encodings (00 = bus idle)
package system_bus_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/system_bus_arbiter.sv
// Registered round-robin arbiter for two masters.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   request : request[i] = master i wants the bus
//   grant   : registered one-hot grant, 00 when idle
// The owner keeps the bus while it requests. When it drops, the bus is
// handed straight to the other master if it is requesting. From idle, a
// single requester wins outright and a tie goes to the master favoured by
// the pointer. Every new grant moves the pointer to favour the other master.
module bus_arbiter
  import system_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] request,
  output logic [1:0] grant
);

  master_e favour;

  // NOTE: state registers use non-blocking assignments so every branch
  // reads the pre-edge grant/pointer values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant  <= GNT_NONE;
      favour <= M0;
    end else begin
      case (grant)
        GNT_M0: begin
          if (!request[0]) begin
            if (request[1]) begin
              grant  <= GNT_M1;
              favour <= M0;
            end else begin
              grant  <= GNT_NONE;
            end
          end
        end
        GNT_M1: begin
          if (!request[1]) begin
            if (request[0]) begin
              grant  <= GNT_M0;
              favour <= M1;
            end else begin
              grant  <= GNT_NONE;
            end
          end
        end
        default: begin
          // Idle (11 is unreachable and recovers through here as well).
          case (request)
            2'b01: begin
              grant  <= GNT_M0;
              favour <= M1;
            end
            2'b10: begin
              grant  <= GNT_M1;
              favour <= M0;
            end
            2'b11: begin
              if (favour == M0) begin
                grant  <= GNT_M0;
                favour <= M1;
              end else begin
                grant  <= GNT_M1;
                favour <= M0;
              end
            end
            default: grant <= GNT_NONE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/system_bus.sv
// Two-master shared-memory system bus for the dual-core CPU.
//   clk        : system clock
//   reset      : asynchronous active-low reset (0 = in reset)
//   request    : per-master bus request
//   adr0/adr1  : word addresses of master 0 / master 1
//   writedata0/writedata1, memwrite0/memwrite1 : write data and enables
//   grant      : registered one-hot grant, 00 = idle
//   memdata    : mem[address of granted master], 0 when idle
// The arbiter picks the owner; only the owner's address, data and write
// enable reach the 2^WIDTH x WIDTH memory.
module system_bus
  import system_bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       request,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] writedata0,
  input  logic [WIDTH-1:0] writedata1,
  input  logic             memwrite0,
  input  logic             memwrite1,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] memdata
);

  localparam int DEPTH = 2 ** WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  bus_arbiter u_arbiter (
    .clk     (clk),
    .rst_n   (reset),
    .request (request),
    .grant   (grant)
  );

  // NOTE: the memory array has no reset branch; its contents come from the
  // configuration state and survive reset. Writes are still gated by reset
  // so a transfer caught by reset on the same edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (grant == GNT_M0 && memwrite0) begin
        mem[adr0] <= writedata0;
      end else if (grant == GNT_M1 && memwrite1) begin
        mem[adr1] <= writedata1;
      end
    end
  end

  // NOTE: memdata gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    memdata = '0;
    case (grant)
      GNT_M0:  memdata = mem[adr0];
      GNT_M1:  memdata = mem[adr1];
      default: memdata = '0;
    endcase
  end

endmodule

// File: tb/tb_system_bus.sv
// Directed self-checking bench for system_bus (WIDTH = 8).
module tb_system_bus;

  logic       clk;
  logic       reset;
  logic [1:0] request;
  logic [7:0] adr0, adr1, writedata0, writedata1;
  logic       memwrite0, memwrite1;
  logic [1:0] grant;
  logic [7:0] memdata;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference arbitration state for the request sweep.
  logic [1:0] exp_grant;
  logic       exp_fav;   // 0 favours master 0, 1 favours master 1

  system_bus #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .adr0       (adr0),
    .adr1       (adr1),
    .writedata0 (writedata0),
    .writedata1 (writedata1),
    .memwrite0  (memwrite0),
    .memwrite1  (memwrite1),
    .grant      (grant),
    .memdata    (memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; request = 2'b11;
    adr0 = '0; adr1 = '0; writedata0 = '0; writedata1 = '0;
    memwrite0 = 1'b0; memwrite1 = 1'b0;

    // Reset held with both masters requesting.
    tick(); tick();
    check("reset_grant", {6'd0, grant}, 8'h00);
    check("reset_memdata", memdata, 8'h00);

    // Release: tie from idle goes to master 0.
    reset = 1'b1;
    tick();
    check("first_grant", {6'd0, grant}, 8'h01);

    // Master 0 writes 207 to address 5.
    request = 2'b01; adr0 = 8'd5; writedata0 = 8'd207; memwrite0 = 1'b1;
    tick();
    memwrite0 = 1'b0;
    check("m0_keeps", {6'd0, grant}, 8'h01);
    #1 check("m0_readback", memdata, 8'd207);

    // Master 1 requests and tries to write while master 0 owns the bus.
    request = 2'b11; adr1 = 8'd5; writedata1 = 8'd55; memwrite1 = 1'b1;
    tick();
    check("no_preempt", {6'd0, grant}, 8'h01);
    check("ignored_write", memdata, 8'd207);

    // Master 0 drops: direct handover; old word visible during the write.
    request = 2'b10;
    tick();
    check("handover", {6'd0, grant}, 8'h02);
    check("read_old_word", memdata, 8'd207);
    tick();
    memwrite1 = 1'b0;
    check("m1_readback", memdata, 8'd55);

    // Non-granted master's address has no effect on the read path.
    adr0 = 8'd7;
    #1 check("other_adr_ignored", memdata, 8'd55);

    // Idle/contend toggling: grants alternate.
    request = 2'b00; tick();
    check("idle_grant", {6'd0, grant}, 8'h00);
    check("idle_memdata", memdata, 8'h00);
    request = 2'b11; tick();
    check("alt_1", {6'd0, grant}, 8'h01);
    request = 2'b00; tick();
    request = 2'b11; tick();
    check("alt_2", {6'd0, grant}, 8'h02);
    request = 2'b00; tick();
    request = 2'b11; tick();
    check("alt_3", {6'd0, grant}, 8'h01);
    request = 2'b00; tick();
    request = 2'b11; tick();
    check("alt_4", {6'd0, grant}, 8'h02);

    // Master 1 owns; write 11 to address 9.
    adr1 = 8'd9; writedata1 = 8'd11; memwrite1 = 1'b1;
    tick();
    check("m1_write9", memdata, 8'd11);

    // Reset mid-transfer: grant clears at once, the pending write is lost.
    writedata1 = 8'd99;
    reset = 1'b0;
    #1 check("async_clear", {6'd0, grant}, 8'h00);
    tick();
    reset = 1'b1; memwrite1 = 1'b0; request = 2'b10;
    tick();
    check("post_reset_grant", {6'd0, grant}, 8'h02);
    check("write_dropped", memdata, 8'd11);

    // Counter sweep of request against a reference arbiter.
    reset = 1'b0; request = 2'b00;
    tick();
    reset = 1'b1;
    exp_grant = 2'b00; exp_fav = 1'b0;
    for (int i = 0; i < 40; i++) begin
      request = i[1:0];
      tick();
      if (exp_grant == 2'b01 && request[0]) begin
        exp_grant = 2'b01;
      end else if (exp_grant == 2'b10 && request[1]) begin
        exp_grant = 2'b10;
      end else if (exp_grant == 2'b01) begin
        exp_grant = request[1] ? 2'b10 : 2'b00;
        if (request[1]) exp_fav = 1'b0;
      end else if (exp_grant == 2'b10) begin
        exp_grant = request[0] ? 2'b01 : 2'b00;
        if (request[0]) exp_fav = 1'b1;
      end else if (request == 2'b01 || (request == 2'b11 && !exp_fav)) begin
        exp_grant = 2'b01; exp_fav = 1'b1;
      end else if (request == 2'b10 || request == 2'b11) begin
        exp_grant = 2'b10; exp_fav = 1'b0;
      end else begin
        exp_grant = 2'b00;
      end
      check("sweep_not_11", {7'd0, grant == 2'b11}, 8'h00);
      check("sweep_grant", {6'd0, grant}, {6'd0, exp_grant});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
